// File: rtl/bcd_to_gray_enc.sv
// bcd_to_gray_enc: two-digit BCD (0..15) to 4-bit plain binary or Gray encoder.
// Latency: 2 cycles (accept at edge N, out_valid visible from cycle N+2); 1 beat/cycle.
// Backpressure: valid/ready both sides; 2-beat capacity; output held stable while stalled.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   in_valid/in_ready  input handshake; in[4] = tens digit, in[3:0] = units digit
//   tog                per-beat mode, captured with the beat (1 = Gray, 0 = binary)
//   out_valid/out_ready output handshake
//   out, out_err       encoded value, and flag for a malformed/out-of-range BCD beat
//   err_cnt            saturating count of accepted invalid beats
//
// Build option: define BCD_ERRCNT_EN to implement err_cnt; otherwise it reads 0.
module bcd_to_gray_enc (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in,
  input  logic       tog,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out,
  output logic       out_err,
  output logic [7:0] err_cnt
);

  // Stage 1 registers
  logic       r_s1_v;
  logic [3:0] r_s1_bin;
  logic       r_s1_tog;
  logic       r_s1_err;

  // Stage 2 registers (drive the outputs directly)
  logic       r_s2_v;
  logic [3:0] r_s2_out;
  logic       r_s2_err;

  logic       w_in_xfer;
  logic       w_s2_load;
  logic       w_in_invalid;
  logic [3:0] w_in_bin;
  logic [3:0] w_s1_enc;

  // S1 frees up whenever it is empty or its beat moves to S2 this cycle.
  // Held low during reset so no beat is taken while the pipe is being flushed.
  assign in_ready  = !rst && (!r_s1_v || !r_s2_v || out_ready);
  assign w_in_xfer = in_valid && in_ready;
  assign w_s2_load = r_s1_v && (!r_s2_v || out_ready);

  // Units above 9, or tens=1 with units above 5 (value above 15), are not encodable.
  assign w_in_invalid = (in[3:0] > 4'd9) || (in[4] && (in[3:0] > 4'd5));

  // Valid inputs never exceed 15, so the 4-bit add cannot wrap for them;
  // invalid beats are forced to zero.
  always_comb begin
    w_in_bin = 4'd0;
    if (!w_in_invalid) begin
      w_in_bin = in[4] ? (in[3:0] + 4'd10) : in[3:0];
    end
  end

  // Encoding uses the mode captured with the beat, not the live tog pin.
  assign w_s1_enc = r_s1_tog ? (r_s1_bin ^ {1'b0, r_s1_bin[3:1]}) : r_s1_bin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v   <= 1'b0;
      r_s1_bin <= 4'd0;
      r_s1_tog <= 1'b0;
      r_s1_err <= 1'b0;
    end else if (w_in_xfer) begin
      r_s1_v   <= 1'b1;
      r_s1_bin <= w_in_bin;
      r_s1_tog <= tog;
      r_s1_err <= w_in_invalid;
    end else if (w_s2_load) begin
      r_s1_v   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_v   <= 1'b0;
      r_s2_out <= 4'd0;
      r_s2_err <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_v   <= 1'b1;
      r_s2_out <= w_s1_enc;
      r_s2_err <= r_s1_err;
    end else if (r_s2_v && out_ready) begin
      r_s2_v   <= 1'b0;
    end
  end

  assign out_valid = r_s2_v;
  assign out       = r_s2_out;
  assign out_err   = r_s2_err;

`ifdef BCD_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= 8'd0;
    end else if (w_in_xfer && w_in_invalid && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_bcd_to_gray_enc.sv
// tb_bcd_to_gray_enc: scoreboard bench for bcd_to_gray_enc.
// Expected beats are queued at acceptance; a negedge monitor pops on each output transfer.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_bcd_to_gray_enc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_dat = 5'd0;
  logic       tog = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out;
  logic       out_err;
  logic [7:0] err_cnt;

  int checks = 0;
  int failures = 0;
  int errs = 0;           // invalid beats accepted since last reset
  logic [4:0] sb[$];      // expected {err, out}
  logic [4:0] obs[$];     // observed {err, out}, for directed checks

  bcd_to_gray_enc dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in(in_dat), .tog(tog),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_err(out_err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: decimal value of the two digits; anything that is not a
  // proper digit pair in 0..15 is an error beat with value 0.
  function automatic logic [4:0] model(input logic [4:0] v, input logic t);
    int units, value, b;
    bit bad;
    units = int'(v[3:0]);
    value = int'(v[4]) * 10 + units;
    bad   = (units > 9) || (value > 15);
    b     = bad ? 0 : value;
    if (t) b = b ^ (b / 2);
    return {bad, 4'(b)};
  endfunction

  function automatic int exp_cnt();
`ifdef BCD_ERRCNT_EN
    return (errs > 255) ? 255 : errs;
`else
    return 0;
`endif
  endfunction

  // Output monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got out=%0d err=%0d with empty scoreboard", out, out_err);
      end else begin
        logic [4:0] e;
        e = sb.pop_front();
        chk("beat_out", int'(out), int'(e[3:0]));
        chk("beat_err", int'(out_err), int'(e[4]));
        obs.push_back({out_err, out});
      end
    end
  end

  // Offer one beat; called at posedge+1, returns at posedge+1.
  task automatic send(input logic [4:0] v, input logic t, input int budget,
                      output bit ok, output int waited);
    logic [4:0] e;
    in_dat = v; tog = t; in_valid = 1'b1; ok = 1'b0; waited = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        e = model(v, t);
        sb.push_back(e);
        if (e[4]) errs++;
        ok = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, sb.size(), 0);
  endtask

  bit ok, ok1, ok2, ok3;
  int w, wsum;
  bit rand_done;
  logic [4:0] e_first;

  initial begin
    // Reset then idle
    @(posedge clk); #1;
    chk("in_ready_in_rst", int'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out", int'(out), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // Latency with an empty pipeline
    out_ready = 1'b1;
    send(5'b0_0111, 1'b0, 10, ok, w);
    chk("lat_accept", int'(ok), 1);
    @(negedge clk);
    chk("lat_not_yet", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_visible", int'(out_valid), 1);
    @(posedge clk); #1;
    drain("lat_drain", 20);

    // Valid conversions back to back
    obs.delete();
    wsum = 0;
    send(5'b1_0101, 1'b1, 10, ok, w); wsum += w;
    send(5'b1_0101, 1'b0, 10, ok, w); wsum += w;
    send(5'b0_1001, 1'b1, 10, ok, w); wsum += w;
    send(5'b1_0000, 1'b0, 10, ok, w); wsum += w;
    chk("throughput_stalls", wsum, 0);
    drain("conv_drain", 20);
    chk("conv_count", obs.size(), 4);
    if (obs.size() == 4) begin
      chk("conv0", int'(obs[0]), 5'b0_1000);
      chk("conv1", int'(obs[1]), 5'b0_1111);
      chk("conv2", int'(obs[2]), 5'b0_1101);
      chk("conv3", int'(obs[3]), 5'b0_1010);
    end

    // Invalid inputs
    obs.delete();
    send(5'b0_1010, 1'b1, 10, ok, w);
    send(5'b1_0110, 1'b0, 10, ok, w);
    drain("inv_drain", 20);
    chk("inv_count", obs.size(), 2);
    if (obs.size() == 2) begin
      chk("inv0", int'(obs[0]), 5'b1_0000);
      chk("inv1", int'(obs[1]), 5'b1_0000);
    end
    chk("inv_err_cnt", int'(err_cnt), exp_cnt());

    // Backpressure: only two beats fit
    out_ready = 1'b0;
    e_first = model(5'b0_0110, 1'b1);
    send(5'b0_0110, 1'b1, 5, ok1, w);
    send(5'b0_1000, 1'b0, 5, ok2, w);
    chk("bp_in_ready_full", int'(in_ready), 0);
    send(5'b0_0001, 1'b1, 5, ok3, w);
    chk("bp_accepted", int'(ok1) + int'(ok2) + int'(ok3), 2);
    chk("bp_third_refused", int'(ok3), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_out", int'({out_err, out}), int'(e_first));
    end
    @(posedge clk); #1;
    obs.delete();
    out_ready = 1'b1;
    drain("bp_drain", 20);
    chk("bp_count", obs.size(), 2);
    send(5'b0_0001, 1'b1, 10, ok, w);
    drain("bp_third_drain", 20);

    // Mode captured with the beat
    obs.delete();
    send(5'b0_0011, 1'b1, 10, ok, w);
    tog = 1'b0;
    drain("mode_drain", 20);
    chk("mode_count", obs.size(), 1);
    if (obs.size() == 1) chk("mode_out", int'(obs[0]), 5'b0_0010);

    // Random traffic with random output stalls
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          send(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 50, ok, w);
          if (!ok) chk("rand_accept", 0, 1);
          if ($urandom_range(0, 3) == 0) cycles(1);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain("rand_drain", 50);
    chk("rand_err_cnt", int'(err_cnt), exp_cnt());

    // Saturation
    for (int n = 0; n < 260; n++) begin
      send(5'b1_1111, 1'($urandom_range(0, 1)), 20, ok, w);
    end
    drain("sat_drain", 50);
    chk("sat_err_cnt", int'(err_cnt), exp_cnt());

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(5'b0_0010, 1'b0, 10, ok1, w);
    send(5'b0_0100, 1'b1, 10, ok2, w);
    chk("mid_two_accepted", int'(ok1) + int'(ok2), 2);
    rst = 1'b1;
    sb.delete();
    errs = 0;
    cycles(2);
    chk("mid_in_ready_rst", int'(in_ready), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mid_no_output", int'(out_valid), 0);
    end
    chk("mid_err_cnt", int'(err_cnt), 0);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time budget");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
